// File: rtl/dmem_responder.sv
// dmem_responder
// Line-granular data memory that serves the data cache's miss (read) and
// write-back (write) requests after a fixed, parameterised latency.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset (0 = reset)
//   MemRead    line read request, level, held until MemReady is seen
//   MemWrite   line write request, level, held until MemReady is seen
//   AMem       line address (ADDR_W bits)
//   WriteLine  line data for writes (LINE_W bits)
//   MemLine    registered read data; holds until the next read completes
//   MemReady   one-cycle completion pulse
//   MemErr     (only with DMEM_ERR_EN) pulses with MemReady when the served
//              request had both MemRead and MemWrite set, or an address >= DEPTH
//
// Optional feature macro: DMEM_ERR_EN
//
// Timing: a request seen in IDLE at edge k is latched and MemReady is high
// after edge k+LATENCY. The read or write takes effect at that same edge.
// The block then waits in DONE until both request lines are low at an edge,
// so a request that is still held is never served twice.
//
// The line array itself has no reset; only control and MemLine are cleared.
module dmem_responder #(
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] AMem,
  input  logic [LINE_W-1:0] WriteLine,
  output logic [LINE_W-1:0] MemLine,
  output logic              MemReady
`ifdef DMEM_ERR_EN
  ,
  output logic              MemErr
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic [LINE_W-1:0] line_q, line_d;
`ifdef DMEM_ERR_EN
  logic              both_q, both_d;
  logic              err_q, err_d;
`endif

  logic [LINE_W-1:0] mem [DEPTH];

  logic              lastEdge;
  logic              inRange;
  logic [IDX_W-1:0]  idx;
  logic              memWrEn;

  // The counter reaches zero exactly at the edge that completes the request.
  assign lastEdge = (state_q == BUSY) && (cnt_q == 8'd0);
  assign inRange  = 32'(addr_q) < 32'(DEPTH);
  assign idx      = addr_q[IDX_W-1:0];

  // State register plus all latched request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      line_q  <= '0;
`ifdef DMEM_ERR_EN
      both_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      line_q  <= line_d;
`ifdef DMEM_ERR_EN
      both_q  <= both_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next state. Request inputs are only sampled in IDLE; a simultaneous
  // read+write is treated as a write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
`ifdef DMEM_ERR_EN
    both_d  = both_q;
`endif
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          addr_d  = AMem;
          wdata_d = WriteLine;
          wr_d    = MemWrite;
`ifdef DMEM_ERR_EN
          both_d  = MemRead && MemWrite;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE: begin
        if (!MemRead && !MemWrite) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: MemReady is only set on the completing edge, so it drops again
  // one edge later. Out-of-range reads return zero, out-of-range writes are dropped.
  always_comb begin
    ready_d = lastEdge;
    line_d  = line_q;
    memWrEn = 1'b0;
    if (lastEdge) begin
      if (wr_q) memWrEn = inRange;
      else      line_d  = inRange ? mem[idx] : '0;
    end
`ifdef DMEM_ERR_EN
    err_d = lastEdge && (both_q || !inRange);
`endif
  end

  // Write commit. Gated by the reset-cleared state, so a write interrupted
  // by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (memWrEn) mem[idx] <= wdata_q;
  end

  assign MemLine  = line_q;
  assign MemReady = ready_q;
`ifdef DMEM_ERR_EN
  assign MemErr   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (LATENCY=5/DEPTH=1024 and
// LATENCY=1/DEPTH=512) driven by directed and random line transactions and
// compared against a simple array-based model of the line store.
module tb_dmem_responder;

  localparam int LW   = 128;
  localparam int AW   = 10;
  localparam int LAT0 = 5;
  localparam int DEP0 = 1024;
  localparam int LAT1 = 1;
  localparam int DEP1 = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          memRead   [2];
  logic          memWrite  [2];
  logic [AW-1:0] aMem      [2];
  logic [LW-1:0] writeLine [2];
  logic [LW-1:0] line0, line1;
  logic          ready0, ready1;
`ifdef DMEM_ERR_EN
  logic          err0, err1;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Model: expected line store per instance and expected MemLine value.
  logic [LW-1:0] model [2][1024];
  logic [LW-1:0] lastLine [2];

  dmem_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(DEP0), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
    .AMem(aMem[0]), .WriteLine(writeLine[0]), .MemLine(line0), .MemReady(ready0)
`ifdef DMEM_ERR_EN
    , .MemErr(err0)
`endif
  );

  dmem_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(DEP1), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
    .AMem(aMem[1]), .WriteLine(writeLine[1]), .MemLine(line1), .MemReady(ready1)
`ifdef DMEM_ERR_EN
    , .MemErr(err1)
`endif
  );

  function automatic int latOf(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int depOf(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic readyOf(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction

  function automatic logic [LW-1:0] lineOf(input int d);
    return (d == 0) ? line0 : line1;
  endfunction

`ifdef DMEM_ERR_EN
  function automatic logic errOf(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
`endif

  function automatic logic [LW-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; must be called right after a falling edge.
  // While the request is in flight AMem/WriteLine are scrambled, which the
  // DUT must ignore. After MemReady the request is held for 'hold' cycles.
  task automatic applyStimulus(input int d, input bit rd, input bit wr,
                               input logic [AW-1:0] addr, input logic [LW-1:0] data,
                               input int hold);
    int cycles;
    bit seen;
    bit oob;
    oob = int'(addr) >= depOf(d);
    memRead[d]   = rd;
    memWrite[d]  = wr;
    aMem[d]      = addr;
    writeLine[d] = data;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (readyOf(d)) seen = 1'b1;
      else begin
        aMem[d]      = AW'($urandom);
        writeLine[d] = randLine();
      end
    end
    checkOutput($sformatf("latency d%0d a%0h", d, addr), LW'(cycles - 1), LW'(latOf(d)));
    if (wr) begin
      if (!oob) model[d][addr] = data;
    end else begin
      lastLine[d] = oob ? '0 : model[d][addr];
    end
    checkOutput($sformatf("line d%0d a%0h", d, addr), lineOf(d), lastLine[d]);
`ifdef DMEM_ERR_EN
    checkOutput($sformatf("err d%0d a%0h", d, addr), LW'(errOf(d)), LW'((rd && wr) || oob));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput($sformatf("heldReady d%0d", d), LW'(readyOf(d)), '0);
    end
    memRead[d]  = 1'b0;
    memWrite[d] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("pulseEnd d%0d", d), LW'(readyOf(d)), '0);
    checkOutput($sformatf("lineHold d%0d", d), lineOf(d), lastLine[d]);
  endtask

  logic [AW-1:0] pool [2][6];
  logic [LW-1:0] oldData;
  int            pulses;
  int            guard;

  initial begin
    pool[0] = '{10'h012, 10'h0A3, 10'h005, 10'h040, 10'h100, 10'h3FF};
    pool[1] = '{10'h000, 10'h0FF, 10'h1FF, 10'h155, 10'h200, 10'h3FF};
    for (int d = 0; d < 2; d++) begin
      memRead[d] = 1'b0; memWrite[d] = 1'b0; aMem[d] = '0; writeLine[d] = '0;
      lastLine[d] = '0;
    end

    // Reset state.
    rst = 1'b0;
    #3;
    checkOutput("rstReady0", LW'(ready0), '0);
    checkOutput("rstReady1", LW'(ready1), '0);
    checkOutput("rstLine0", line0, '0);
    checkOutput("rstLine1", line1, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Preload every in-range pool address so later reads have defined data.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++)
        if (int'(pool[d][i]) < depOf(d)) applyStimulus(d, 0, 1, pool[d][i], randLine(), 0);

    // Read latency with a known pattern in word 0.
    applyStimulus(0, 0, 1, 10'h012, {96'h0123_4567_89AB_CDEF_0F0F_0F0F, 32'hDEADBEEF}, 0);
    applyStimulus(0, 1, 0, 10'h012, '0, 0);
    checkOutput("word0", LW'(line0[31:0]), LW'(32'hDEADBEEF));

    // Write then read back.
    applyStimulus(0, 0, 1, 10'h0A3, 128'h11112222333344445555666677778888, 0);
    applyStimulus(0, 1, 0, 10'h0A3, '0, 0);

    // Held request: one pulse only, then a fresh request accepted at once.
    applyStimulus(0, 1, 0, 10'h012, '0, 20);
    applyStimulus(0, 1, 0, 10'h0A3, '0, 0);

    // Simultaneous read+write is a write; MemLine keeps the last read.
    applyStimulus(0, 1, 1, 10'h005, '1, 0);
    applyStimulus(0, 1, 0, 10'h005, '0, 0);

    // Async reset mid-write: the write must be discarded.
    oldData = randLine();
    applyStimulus(0, 0, 1, 10'h040, oldData, 0);
    memWrite[0] = 1'b1; aMem[0] = 10'h040; writeLine[0] = ~oldData;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midWrReady", LW'(ready0), '0);
    checkOutput("midWrLine", line0, '0);
    lastLine[0] = '0; lastLine[1] = '0;
    @(negedge clk);
    memWrite[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 0, 10'h040, '0, 0);

    // Async reset while MemReady is high clears it without a clock edge.
    memRead[0] = 1'b1; aMem[0] = 10'h012;
    guard = 0;
    while (!ready0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("preRstReady", LW'(ready0), LW'(1));
    #1 rst = 1'b0;
    #1;
    checkOutput("asyncReady", LW'(ready0), '0);
    checkOutput("asyncLine", line0, '0);
    lastLine[0] = '0; lastLine[1] = '0;
    @(negedge clk);
    memRead[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // In-flight read killed by reset produces no MemReady.
    memRead[0] = 1'b1; aMem[0] = 10'h0A3;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    memRead[0] = 1'b0;
    rst = 1'b1;
    pulses = 0;
    repeat (LAT0 + 3) begin
      @(negedge clk);
      if (ready0) pulses++;
    end
    checkOutput("killedRead", LW'(pulses), '0);

    // Boundary instance: latency 1, out-of-range write dropped and read is zero.
    applyStimulus(1, 0, 1, 10'h3FF, randLine(), 0);
    applyStimulus(1, 1, 0, 10'h3FF, '0, 0);
    applyStimulus(1, 0, 1, 10'h1FF, randLine(), 0);
    applyStimulus(1, 1, 0, 10'h1FF, '0, 1);
    applyStimulus(1, 1, 0, 10'h200, '0, 0);

    // Random traffic over a small address pool on both instances.
    for (int n = 0; n < 40; n++) begin
      int d;
      int op;
      d  = n % 2;
      op = $urandom_range(1, 3);
      applyStimulus(d, op != 2, op != 1, pool[d][$urandom_range(0, 5)], randLine(),
                    $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
